uart_cmd_decoder: RTL

- Consumer-side counterpart of `uart_rx`. It sits on the received-byte handshake (`received_data_p`, `received_data_read_req_p`, `received_data_ack_p`) and owns `received_data_ack_p`.
- Acknowledges every byte and parses the byte stream into command frames: SYNC, CMD, LEN, PAYLOAD[LEN], CSUM.
- Presents each validated command to on-board logic, with a held-valid/ack handshake and a payload read port.

---
 rtl/uart_cmd_decoder_pkg.sv | 28 ++
 rtl/uart_cmd_decoder_byte_sink.sv | 66 ++++++
 rtl/uart_cmd_decoder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_decoder_pkg.sv
// Shared types and defaults for the UART command decoder and its byte sink.
package uart_cmd_pkg;

  localparam int         MAX_PAYLOAD_DEFAULT = 16;
  localparam logic [7:0] SYNC_BYTE_DEFAULT   = 8'hA5;

  // Frame parser states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CSUM    = 3'd4,
    HOLD    = 3'd5
  } parser_state_e;

  // Four-phase req/ack handshake states
  typedef enum logic {
    WAIT_REQ = 1'b0,
    ACK_HIGH = 1'b1
  } ack_state_e;

  // Running frame checksum: plain XOR over CMD, LEN and payload
  function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_byte_sink.sv
// uart_byte_sink: consumer side of the uart_rx four-phase byte handshake.
// One strobe per req assertion; a byte is only taken while ready is high.
module uart_byte_sink
  import uart_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] data,
  input  logic       ready,
  output logic       ack,
  output logic       strobe,
  output logic [7:0] rx_byte
);

  ack_state_e state_r;
  ack_state_e next_state_s;
  logic       ack_r;
  logic       strobe_s;
  logic [7:0] byte_r;

  // Handshake state register, registered ack and latched byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= WAIT_REQ;
      ack_r   <= 1'b0;
      byte_r  <= 8'h00;
    end else begin
      state_r <= next_state_s;
      ack_r   <= (next_state_s == ACK_HIGH);
      if (strobe_s) begin
        byte_r <= data;
      end
    end
  end

  // Take a byte when requested and ready; release ack once req drops
  always_comb begin
    next_state_s = state_r;
    strobe_s     = 1'b0;
    case (state_r)
      WAIT_REQ: begin
        if (req && ready) begin
          strobe_s     = 1'b1;
          next_state_s = ACK_HIGH;
        end else begin
          next_state_s = WAIT_REQ;
        end
      end
      ACK_HIGH: begin
        if (!req) begin
          next_state_s = WAIT_REQ;
        end else begin
          next_state_s = ACK_HIGH;
        end
      end
      default: next_state_s = WAIT_REQ;
    endcase
  end

  // Byte is valid on the strobe cycle itself (req holds data stable)
  assign rx_byte = strobe_s ? data : byte_r;
  assign strobe  = strobe_s;
  assign ack     = ack_r;

endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: parses SYNC/CMD/LEN/PAYLOAD/CSUM frames from uart_rx and
// holds each validated command until the consumer acknowledges it.
// Optional inter-byte timeout: define UART_CMD_TIMEOUT_EN.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int         MAX_PAYLOAD = MAX_PAYLOAD_DEFAULT,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
`ifdef UART_CMD_TIMEOUT_EN
  ,parameter int        TIMEOUT_CYCLES = 2100000
`endif
)(
  input  logic                               clk210_p,
  input  logic                               reset_p,
  input  logic [7:0]                         received_data_p,
  input  logic                               received_data_read_req_p,
  output logic                               received_data_ack_p,
  output logic                               cmd_valid_p,
  input  logic                               cmd_ack_p,
  output logic [7:0]                         cmd_p,
  output logic [$clog2(MAX_PAYLOAD+1)-1:0]   cmd_len_p,
  input  logic [$clog2(MAX_PAYLOAD)-1:0]     payload_rd_addr_p,
  output logic [7:0]                         payload_rd_data_p,
  output logic                               checksum_err_p,
  output logic                               len_err_p
`ifdef UART_CMD_TIMEOUT_EN
  ,output logic                              timeout_err_p
`endif
);

  localparam int         LW        = $clog2(MAX_PAYLOAD + 1);
  localparam int         AW        = $clog2(MAX_PAYLOAD);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_PAYLOAD);

  parser_state_e state_r, parse_next_s, next_state_s;
  logic          strobe_s;
  logic [7:0]    rx_byte_s;
  logic [7:0]    cmd_r, csum_r, rd_data_r;
  logic [LW-1:0] len_r;
  logic [AW-1:0] idx_r;
  logic          cmd_valid_r, csum_err_r, len_err_r;
  logic          csum_err_s, len_err_s, last_byte_s;
  logic [7:0]    ram_r [MAX_PAYLOAD];

  // No new byte is accepted while a command is held
  uart_byte_sink u_sink (
    .clk     (clk210_p),
    .rst     (reset_p),
    .req     (received_data_read_req_p),
    .data    (received_data_p),
    .ready   (state_r != HOLD),
    .ack     (received_data_ack_p),
    .strobe  (strobe_s),
    .rx_byte (rx_byte_s)
  );

  assign last_byte_s = (LW'(idx_r) == (len_r - LW'(1'b1)));

  // Frame parser next-state and error pulse decisions
  always_comb begin
    parse_next_s = state_r;
    csum_err_s   = 1'b0;
    len_err_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (strobe_s && (rx_byte_s == SYNC_BYTE)) begin
          parse_next_s = CMD;
        end else begin
          parse_next_s = IDLE;
        end
      end
      CMD: begin
        if (strobe_s) begin
          parse_next_s = LEN;
        end else begin
          parse_next_s = CMD;
        end
      end
      LEN: begin
        if (strobe_s) begin
          if (rx_byte_s > MAX_LEN_B) begin
            len_err_s    = 1'b1;
            parse_next_s = IDLE;
          end else if (rx_byte_s == 8'h00) begin
            parse_next_s = CSUM;
          end else begin
            parse_next_s = PAYLOAD;
          end
        end else begin
          parse_next_s = LEN;
        end
      end
      PAYLOAD: begin
        if (strobe_s && last_byte_s) begin
          parse_next_s = CSUM;
        end else begin
          parse_next_s = PAYLOAD;
        end
      end
      CSUM: begin
        if (strobe_s) begin
          if (rx_byte_s == csum_r) begin
            parse_next_s = HOLD;
          end else begin
            csum_err_s   = 1'b1;
            parse_next_s = IDLE;
          end
        end else begin
          parse_next_s = CSUM;
        end
      end
      HOLD: begin
        if (cmd_ack_p) begin
          parse_next_s = IDLE;
        end else begin
          parse_next_s = HOLD;
        end
      end
      default: parse_next_s = IDLE;
    endcase
  end

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt_r;
  logic          tmo_active_s, tmo_hit_s, timeout_err_r;

  assign tmo_active_s = (state_r == CMD) || (state_r == LEN) ||
                        (state_r == PAYLOAD) || (state_r == CSUM);
  // A byte arriving on the expiry cycle wins over the timeout
  assign tmo_hit_s    = tmo_active_s && !strobe_s && (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));
  assign next_state_s = tmo_hit_s ? IDLE : parse_next_s;

  // Inter-byte timer: runs mid-frame, cleared by every byte and outside frames
  always_ff @(posedge clk210_p or posedge reset_p) begin
    if (reset_p) begin
      tmo_cnt_r     <= {TW{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= tmo_hit_s;
      if (!tmo_active_s || strobe_s || tmo_hit_s) begin
        tmo_cnt_r <= {TW{1'b0}};
      end else begin
        tmo_cnt_r <= tmo_cnt_r + TW'(1'b1);
      end
    end
  end

  assign timeout_err_p = timeout_err_r;
`else
  assign next_state_s = parse_next_s;
`endif

  // Parser state, command fields, checksum and status outputs
  always_ff @(posedge clk210_p or posedge reset_p) begin
    if (reset_p) begin
      state_r     <= IDLE;
      cmd_r       <= 8'h00;
      len_r       <= {LW{1'b0}};
      idx_r       <= {AW{1'b0}};
      csum_r      <= 8'h00;
      cmd_valid_r <= 1'b0;
      csum_err_r  <= 1'b0;
      len_err_r   <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      cmd_valid_r <= (next_state_s == HOLD);
      csum_err_r  <= csum_err_s;
      len_err_r   <= len_err_s;
      if (strobe_s) begin
        case (state_r)
          IDLE: csum_r <= 8'h00;
          CMD: begin
            cmd_r  <= rx_byte_s;
            csum_r <= csum_update(csum_r, rx_byte_s);
          end
          LEN: begin
            len_r  <= rx_byte_s[LW-1:0];
            idx_r  <= {AW{1'b0}};
            csum_r <= csum_update(csum_r, rx_byte_s);
          end
          PAYLOAD: begin
            idx_r  <= idx_r + AW'(1'b1);
            csum_r <= csum_update(csum_r, rx_byte_s);
          end
          default: csum_r <= csum_r;
        endcase
      end
    end
  end

  // Payload buffer write; contents are don't-care after reset
  always_ff @(posedge clk210_p) begin
    if (strobe_s && (state_r == PAYLOAD)) begin
      ram_r[idx_r] <= rx_byte_s;
    end
  end

  // Registered payload read port, one cycle latency
  always_ff @(posedge clk210_p or posedge reset_p) begin
    if (reset_p) begin
      rd_data_r <= 8'h00;
    end else begin
      rd_data_r <= ram_r[payload_rd_addr_p];
    end
  end

  assign cmd_valid_p       = cmd_valid_r;
  assign cmd_p             = cmd_r;
  assign cmd_len_p         = len_r;
  assign payload_rd_data_p = rd_data_r;
  assign checksum_err_p    = csum_err_r;
  assign len_err_p         = len_err_r;

endmodule
